// File: rtl/led_status_pkg.sv
// Shared types and helpers for the multi-channel LED pattern engine.
// Link-speed decode is only used when F9_LED_LINKSPEED_EN is defined.
package led_status_pkg;

  localparam int LED_MODE_W = 3;

  typedef enum logic [2:0] {
    LED_OFF    = 3'd0,
    LED_ON     = 3'd1,
    LED_SLOW   = 3'd2,
    LED_FAST   = 3'd3,
    LED_BREATH = 3'd4,
    LED_ACT    = 3'd5,
    LED_LINK   = 3'd6,
    LED_RSVD   = 3'd7
  } led_mode_e;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // 1G solid, 100M breathing, 10M slow blink, no link dark
  function automatic led_mode_e led_link_decode(
    input logic [1:0] st
  );
    led_mode_e m;
    unique case (st)
      2'b10:   m = LED_ON;
      2'b01:   m = LED_BREATH;
      2'b11:   m = LED_SLOW;
      default: m = LED_OFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/led_status_engine_act.sv
// Per-channel activity stretcher: a strobe keeps the LED lit
// for STRETCH_T prescaler ticks.
module led_act_stretch
  import led_status_pkg::*;
#(
  parameter int STRETCH_T = 50
) (
  input  logic sys_clk,
  input  logic sys_reset_n,
  input  logic tick,
  input  logic act,
  output logic lit
);

  localparam int CW = cnt_w(STRETCH_T + 1);
  localparam logic [CW-1:0] RELOAD = CW'(STRETCH_T);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // a fresh strobe outranks a coincident tick
  always_comb begin
    cnt_d = cnt_q;
    if (act) begin
      cnt_d = RELOAD;
    end else if (tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign lit = (cnt_q != '0);

endmodule

// File: rtl/led_status_engine.sv
// Multi-channel LED pattern generator sharing one prescaler.
// Define F9_LED_LINKSPEED_EN to add link_st_in and mode 6 LINK.
module led_status_engine
  import led_status_pkg::*;
#(
  parameter int CH_COUNT       = 8,
  parameter int CLK_FREQ_HZ    = 100_000_000,
  parameter int TICK_HZ        = 1000,
  parameter int BLINK_SLOW_T   = 335,
  parameter int BLINK_FAST_T   = 84,
  parameter int PWM_BITS       = 8,
  parameter int BREATH_STEP_T  = 4,
  parameter int ACT_STRETCH_T  = 50,
  parameter int LED_ACTIVE_LOW = 1
) (
  input  logic                           sys_clk,
  input  logic                           sys_reset_n,
  input  logic [CH_COUNT*LED_MODE_W-1:0] mode_in,
  input  logic [CH_COUNT-1:0]            act_in,
`ifdef F9_LED_LINKSPEED_EN
  input  logic [CH_COUNT*2-1:0]          link_st_in,
`endif
  output logic [CH_COUNT-1:0]            led_out,
  output logic                           tick_out
);

  localparam int DIV    = CLK_FREQ_HZ / TICK_HZ;
  localparam int PRE_W  = cnt_w(DIV);
  localparam int SLOW_W = cnt_w(BLINK_SLOW_T);
  localparam int FAST_W = cnt_w(BLINK_FAST_T);
  localparam int STEP_W = cnt_w(BREATH_STEP_T);
  localparam logic POL  = (LED_ACTIVE_LOW != 0);

  localparam logic [PWM_BITS-1:0] LVL_MAX = '1;
  localparam logic [PWM_BITS-1:0] PWM_TOP = LVL_MAX - 1'b1;

  if (DIV < 2) begin : g_bad_div
    $error("led_status_engine: CLK_FREQ_HZ/TICK_HZ must be >= 2");
  end
  if (CH_COUNT < 1 || CH_COUNT > 32) begin : g_bad_ch
    $error("led_status_engine: CH_COUNT must be 1..32");
  end

  logic [PRE_W-1:0]    pre_q, pre_d;
  logic                tick_q, tick_d;
  logic [SLOW_W-1:0]   slow_cnt_q, slow_cnt_d;
  logic                slow_ph_q, slow_ph_d;
  logic [FAST_W-1:0]   fast_cnt_q, fast_cnt_d;
  logic                fast_ph_q, fast_ph_d;
  logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic                dir_dn_q, dir_dn_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [CH_COUNT-1:0] led_q, led_d;
  logic [CH_COUNT-1:0] lit;
  logic                breath_lit;

  always_comb begin
    pre_d  = pre_q + PRE_W'(1);
    tick_d = 1'b0;
    if (pre_q == PRE_W'(DIV - 1)) begin
      pre_d  = '0;
      tick_d = 1'b1;
    end
  end

  always_comb begin
    slow_cnt_d = slow_cnt_q;
    slow_ph_d  = slow_ph_q;
    fast_cnt_d = fast_cnt_q;
    fast_ph_d  = fast_ph_q;
    if (tick_q) begin
      if (slow_cnt_q == SLOW_W'(BLINK_SLOW_T - 1)) begin
        slow_cnt_d = '0;
        slow_ph_d  = ~slow_ph_q;
      end else begin
        slow_cnt_d = slow_cnt_q + SLOW_W'(1);
      end
      if (fast_cnt_q == FAST_W'(BLINK_FAST_T - 1)) begin
        fast_cnt_d = '0;
        fast_ph_d  = ~fast_ph_q;
      end else begin
        fast_cnt_d = fast_cnt_q + FAST_W'(1);
      end
    end
  end

  // direction flips on the step that lands on an endpoint
  always_comb begin
    step_cnt_d = step_cnt_q;
    level_d    = level_q;
    dir_dn_d   = dir_dn_q;
    pwm_d      = (pwm_q == PWM_TOP) ? '0 : pwm_q + 1'b1;
    if (tick_q) begin
      if (step_cnt_q == STEP_W'(BREATH_STEP_T - 1)) begin
        step_cnt_d = '0;
        if (!dir_dn_q) begin
          level_d = level_q + 1'b1;
          if (level_q == LVL_MAX - 1'b1) begin
            dir_dn_d = 1'b1;
          end
        end else begin
          level_d = level_q - 1'b1;
          if (level_q == PWM_BITS'(1)) begin
            dir_dn_d = 1'b0;
          end
        end
      end else begin
        step_cnt_d = step_cnt_q + STEP_W'(1);
      end
    end
  end

  assign breath_lit = (pwm_q < level_q);

  for (genvar g = 0; g < CH_COUNT; g++) begin : g_ch
    led_mode_e md;
    logic      act_lit;
    logic      ch_lit;

    led_act_stretch #(
      .STRETCH_T(ACT_STRETCH_T)
    ) u_act (
      .sys_clk    (sys_clk),
      .sys_reset_n(sys_reset_n),
      .tick       (tick_q),
      .act        (act_in[g]),
      .lit        (act_lit)
    );

    always_comb begin
      md = led_mode_e'(mode_in[LED_MODE_W*g +: LED_MODE_W]);
`ifdef F9_LED_LINKSPEED_EN
      if (md == LED_LINK) begin
        md = led_link_decode(link_st_in[2*g +: 2]);
      end
`endif
      unique case (md)
        LED_ON:     ch_lit = 1'b1;
        LED_SLOW:   ch_lit = slow_ph_q;
        LED_FAST:   ch_lit = fast_ph_q;
        LED_BREATH: ch_lit = breath_lit;
        LED_ACT:    ch_lit = act_lit;
        default:    ch_lit = 1'b0;
      endcase
    end

    assign lit[g] = ch_lit;
  end

  assign led_d = lit ^ {CH_COUNT{POL}};

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      pre_q      <= '0;
      tick_q     <= 1'b0;
      slow_cnt_q <= '0;
      slow_ph_q  <= 1'b0;
      fast_cnt_q <= '0;
      fast_ph_q  <= 1'b0;
      step_cnt_q <= '0;
      level_q    <= '0;
      dir_dn_q   <= 1'b0;
      pwm_q      <= '0;
      led_q      <= {CH_COUNT{POL}};
    end else begin
      pre_q      <= pre_d;
      tick_q     <= tick_d;
      slow_cnt_q <= slow_cnt_d;
      slow_ph_q  <= slow_ph_d;
      fast_cnt_q <= fast_cnt_d;
      fast_ph_q  <= fast_ph_d;
      step_cnt_q <= step_cnt_d;
      level_q    <= level_d;
      dir_dn_q   <= dir_dn_d;
      pwm_q      <= pwm_d;
      led_q      <= led_d;
    end
  end

  assign led_out  = led_q;
  assign tick_out = tick_q;

endmodule

// File: tb/tb_led_status_engine.sv
// Self-checking bench for led_status_engine: vector table,
// directed corner sequences and a cycle-accurate reference model.
module tb_led_status_engine;

  localparam int CH   = 4;
  localparam int DIV  = 10;
  localparam int SLOW = 4;
  localparam int FAST = 2;
  localparam int STR  = 3;
  localparam int PWIN = 7;
  localparam int LMAX = 7;

  typedef struct {
    logic [11:0] mode;
    logic [7:0]  link;
    logic [3:0]  exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] mode;
  logic [3:0]  act;
`ifdef F9_LED_LINKSPEED_EN
  logic [7:0]  link;
`endif
  logic [3:0]  led;
  logic        tick;

  int n_chk = 0;
  int n_fail = 0;
  int k = 0;
  int first_tick = -1;
  bit act_seen [CH];
  int act_tk [CH];
  vec_t tbl [7];

  always #5 clk = ~clk;

  led_status_engine #(
    .CH_COUNT      (CH),
    .CLK_FREQ_HZ   (1000),
    .TICK_HZ       (100),
    .BLINK_SLOW_T  (SLOW),
    .BLINK_FAST_T  (FAST),
    .PWM_BITS      (3),
    .BREATH_STEP_T (1),
    .ACT_STRETCH_T (STR),
    .LED_ACTIVE_LOW(1)
  ) dut (
    .sys_clk    (clk),
    .sys_reset_n(rst_n),
    .mode_in    (mode),
    .act_in     (act),
`ifdef F9_LED_LINKSPEED_EN
    .link_st_in (link),
`endif
    .led_out    (led),
    .tick_out   (tick)
  );

  // ticks consumed by the pattern counters after m edges since reset
  function automatic int ticks_thr(input int m);
    return (m >= 1) ? (m - 1) / DIV : 0;
  endfunction

  function automatic int tri_lvl(input int s);
    int p;
    p = s % (2 * LMAX);
    return (p <= LMAX) ? p : 2 * LMAX - p;
  endfunction

  function automatic bit pat_lit(input int ch, input int m);
    int a;
    int md;
    a  = ticks_thr(m);
    md = int'(mode[3*ch +: 3]);
`ifdef F9_LED_LINKSPEED_EN
    if (md == 6) begin
      case (link[2*ch +: 2])
        2'b10:   md = 1;
        2'b01:   md = 4;
        2'b11:   md = 2;
        default: md = 0;
      endcase
    end
`endif
    case (md)
      1:       return 1'b1;
      2:       return ((a / SLOW) % 2) == 1;
      3:       return ((a / FAST) % 2) == 1;
      4:       return (m % PWIN) < tri_lvl(a);
      5:       return act_seen[ch] && ((a - act_tk[ch]) < STR);
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, got, exp, k);
    end
  endtask

  task automatic step();
    logic [3:0] e;
    @(posedge clk);
    #1;
    k++;
    for (int c = 0; c < CH; c++) e[c] = ~pat_lit(c, k - 1);
    check("led_out", 32'(led), 32'(e));
    check("tick_out", 32'(tick), 32'((k % DIV) == 0));
    if (tick && first_tick < 0) first_tick = k;
    for (int c = 0; c < CH; c++) begin
      if (act[c]) begin
        act_seen[c] = 1'b1;
        act_tk[c]   = ticks_thr(k);
      end
    end
  endtask

  task automatic do_reset(input logic [11:0] md);
    mode = md;
    act  = '0;
    #3 rst_n = 1'b0;
    #1;
    check("rst_led", 32'(led), 32'hF);
    check("rst_tick", 32'(tick), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    first_tick = -1;
    for (int c = 0; c < CH; c++) act_seen[c] = 1'b0;
  endtask

  initial begin
    bit found;

    tbl[0] = '{mode: {4{3'd1}}, link: 8'h00, exp: 4'b0000};
    tbl[1] = '{mode: {4{3'd7}}, link: 8'h00, exp: 4'b1111};
    tbl[2] = '{mode: {3'd1, 3'd0, 3'd7, 3'd1}, link: 8'h00, exp: 4'b0110};
    tbl[3] = '{mode: {4{3'd0}}, link: 8'h00, exp: 4'b1111};
    tbl[4] = '{mode: {3'd7, 3'd7, 3'd7, 3'd1}, link: 8'h00, exp: 4'b1110};
`ifdef F9_LED_LINKSPEED_EN
    tbl[5] = '{mode: {4{3'd6}}, link: 8'hAA, exp: 4'b0000};
`else
    tbl[5] = '{mode: {4{3'd6}}, link: 8'hAA, exp: 4'b1111};
`endif
    tbl[6] = '{mode: {4{3'd1}}, link: 8'h00, exp: 4'b0000};

    for (int c = 0; c < CH; c++) begin
      act_seen[c] = 1'b0;
      act_tk[c]   = 0;
    end

    // ch3 ACT, ch2 BREATH, ch1 FAST, ch0 SLOW from reset
    mode = {3'd5, 3'd4, 3'd3, 3'd2};
    act  = '0;
`ifdef F9_LED_LINKSPEED_EN
    link = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("init_rst_led", 32'(led), 32'hF);
    check("init_rst_tick", 32'(tick), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int c = 1; c <= 400; c++) begin
      step();
      act = '0;
      if (k == 5 || k == 20) act[3] = 1'b1;
    end
    check("first_tick", 32'(first_tick), 32'd10);

    // blink to lit, then OFF must go dark on the next clock
    mode  = {4{3'd2}};
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      step();
      if (led[0] == 1'b0) found = 1'b1;
    end
    check("slow_lit_seen", 32'(found), 32'd1);
    mode = '0;
    step();
    check("off_next_clk", 32'(led), 32'hF);

    for (int i = 0; i < 7; i++) begin
      mode = tbl[i].mode;
`ifdef F9_LED_LINKSPEED_EN
      link = tbl[i].link;
`endif
      step();
      check($sformatf("tbl%0d", i), 32'(led), 32'(tbl[i].exp));
    end

    for (int blk = 0; blk < 24; blk++) begin
      for (int c = 0; c < CH; c++) mode[3*c +: 3] = 3'($urandom_range(0, 7));
`ifdef F9_LED_LINKSPEED_EN
      link = 8'($urandom);
`endif
      if (blk == 12) begin
        mode = {4{3'd1}};
        step();
        step();
        do_reset(mode);
        step();
        for (int c = 0; c < CH; c++) mode[3*c +: 3] = 3'($urandom_range(0, 7));
      end
      repeat (30) begin
        step();
        for (int c = 0; c < CH; c++) act[c] = ($urandom_range(0, 15) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
